// File: rtl/sdpram_stream_fifo_if.sv
// Valid/ready beat stream used on both sides of the RAM-backed FIFO.
// The master drives data and valid; the slave drives ready.
interface sdpram_stream_fifo_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/sdpram_stream_fifo.sv
// Stream FIFO controller around an external SDP RAM: pointers, occupancy, read-latency skid buffer.
// Empty-to-output latency RD_LATENCY+2 edges; s_tready drops only when the RAM holds DEPTH unread words.
module sdpram_stream_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sdpram_stream_fifo_if.slave   s_axis,
    sdpram_stream_fifo_if.master  m_axis,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_enb,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    output logic                  ram_regceb,
    output logic                  ram_rstb,
    input  logic [DATA_WIDTH-1:0] ram_doutb
);
    localparam int SKID_DEPTH = RD_LATENCY + 1;
    localparam int SR_LEN     = RD_LATENCY + 1;
    localparam int SIW        = $clog2(SKID_DEPTH);
    localparam int CW         = $clog2(SKID_DEPTH + 1);
    localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
    logic [SR_LEN-1:0]     vld_sr_q, vld_sr_d;
    logic [DATA_WIDTH-1:0] skid_mem_q [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] skid_mem_d [SKID_DEPTH];
    logic [SIW-1:0]        skid_head_q, skid_head_d;
    logic [SIW-1:0]        skid_tail_q, skid_tail_d;
    logic [CW-1:0]         skid_count_q, skid_count_d;

    logic [CW-1:0] inflight;
    logic [CW:0]   occ;
    logic          s_rdy, m_vld, wr_acc, rd_iss, pop, push;

    function automatic logic [SIW-1:0] skid_next(input logic [SIW-1:0] idx);
        return (idx == SIW'(SKID_DEPTH - 1)) ? '0 : idx + SIW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < SR_LEN; i++) begin
            inflight = inflight + CW'(vld_sr_q[i]);
        end
    end

    // Ready and issue look only at registered state plus this cycle's pop,
    // so a full RAM never accepts on the same cycle a slot is freed.
    always_comb begin
        s_rdy  = !rst && (ram_count_q != CNT_FULL);
        m_vld  = !rst && (skid_count_q != '0);
        wr_acc = s_axis.tvalid && s_rdy;
        pop    = m_vld && m_axis.tready;
        push   = vld_sr_q[SR_LEN-1];
        occ    = {1'b0, inflight} + {1'b0, skid_count_q} - (CW+1)'(pop);
        rd_iss = !rst && (ram_count_q != '0) && (occ < (CW+1)'(SKID_DEPTH));
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q + ADDR_WIDTH'(wr_acc);
        rd_ptr_d     = rd_ptr_q + ADDR_WIDTH'(rd_iss);
        ram_count_d  = ram_count_q + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(rd_iss);
        vld_sr_d     = {vld_sr_q[SR_LEN-2:0], rd_iss};
        skid_mem_d   = skid_mem_q;
        skid_head_d  = skid_head_q;
        skid_tail_d  = skid_tail_q;
        skid_count_d = skid_count_q + CW'(push) - CW'(pop);
        if (push) begin
            skid_mem_d[skid_tail_q] = ram_doutb;
            skid_tail_d             = skid_next(skid_tail_q);
        end
        if (pop) begin
            skid_head_d = skid_next(skid_head_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_count_q  <= '0;
            vld_sr_q     <= '0;
            skid_head_q  <= '0;
            skid_tail_q  <= '0;
            skid_count_q <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skid_mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_count_q  <= ram_count_d;
            vld_sr_q     <= vld_sr_d;
            skid_head_q  <= skid_head_d;
            skid_tail_q  <= skid_tail_d;
            skid_count_q <= skid_count_d;
            skid_mem_q   <= skid_mem_d;
        end
    end

    assign s_axis.tready = s_rdy;
    assign m_axis.tvalid = m_vld;
    assign m_axis.tdata  = rst ? '0 : skid_mem_q[skid_head_q];
    assign level         = rst ? '0 : (ADDR_WIDTH+2)'(ram_count_q) + (ADDR_WIDTH+2)'(inflight)
                                     + (ADDR_WIDTH+2)'(skid_count_q);
    assign ram_ena       = wr_acc;
    assign ram_wea       = wr_acc;
    assign ram_addra     = rst ? '0 : wr_ptr_q;
    assign ram_dina      = s_axis.tdata;
    assign ram_enb       = rd_iss;
    assign ram_addrb     = rst ? '0 : rd_ptr_q;
    assign ram_regceb    = 1'b1;
    assign ram_rstb      = rst;
endmodule

// File: tb/tb_sdpram_stream_fifo.sv
// Bench: three FIFO lanes (RD_LATENCY 1, 2, 4) share one stimulus; each lane has a RAM model and a queue scoreboard.
// Lane 0 also carries the directed timing, capacity, full-boundary and reset checks.
module tb_sdpram_stream_fifo;
    localparam int DW    = 64;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int NL    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          m_tready;

    int n_chk  = 0;
    int n_fail = 0;

    logic          o_srdy [NL];
    logic          o_mvld [NL];
    logic          o_ena [NL];
    logic          o_wea [NL];
    logic          o_enb [NL];
    logic          o_regceb [NL];
    logic          o_rstb [NL];
    logic [DW-1:0] o_mdat [NL];
    logic [AW+1:0] o_lvl [NL];
    logic [AW-1:0] o_addra [NL];
    logic [AW-1:0] o_addrb [NL];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);

        sdpram_stream_fifo_if #(.DATA_WIDTH(DW)) s_if ();
        sdpram_stream_fifo_if #(.DATA_WIDTH(DW)) m_if ();

        logic          ena, wea, enb, regceb, rstb;
        logic [AW-1:0] addra, addrb;
        logic [DW-1:0] dina, doutb;
        logic [AW+1:0] lvl;
        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] pipe [LAT+1];
        logic [DW-1:0] sb [$];

        assign s_if.tdata  = s_tdata;
        assign s_if.tvalid = s_tvalid;
        assign m_if.tready = m_tready;

        sdpram_stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT)) dut (
            .clk(clk), .rst(rst), .s_axis(s_if), .m_axis(m_if), .level(lvl),
            .ram_ena(ena), .ram_wea(wea), .ram_addra(addra), .ram_dina(dina),
            .ram_enb(enb), .ram_addrb(addrb), .ram_regceb(regceb), .ram_rstb(rstb),
            .ram_doutb(doutb)
        );

        // RAM model: word read at the enb-sampling edge appears LAT edges later; junk when idle.
        always @(posedge clk) begin
            if (ena && wea) mem[addra] <= dina;
            pipe[0] <= enb ? mem[addrb] : {$urandom, $urandom};
            for (int i = 1; i <= LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign doutb = pipe[LAT];

        assign o_srdy[g]   = s_if.tready;
        assign o_mvld[g]   = m_if.tvalid;
        assign o_mdat[g]   = m_if.tdata;
        assign o_lvl[g]    = lvl;
        assign o_ena[g]    = ena;
        assign o_wea[g]    = wea;
        assign o_enb[g]    = enb;
        assign o_addra[g]  = addra;
        assign o_addrb[g]  = addrb;
        assign o_regceb[g] = regceb;
        assign o_rstb[g]   = rstb;

        always @(negedge clk) begin
            if (rst) begin
                sb.delete();
            end else begin
                chk($sformatf("lane%0d level", g), 64'(lvl), 64'(sb.size()));
                if (sb.size() == 0) chk($sformatf("lane%0d m_tvalid_empty", g), 64'(m_if.tvalid), 64'd0);
                if (int'(lvl) < DEPTH) chk($sformatf("lane%0d s_tready_room", g), 64'(s_if.tready), 64'd1);
                chk($sformatf("lane%0d skid_bound", g), 64'(int'(dut.skid_count_q) <= LAT + 1), 64'd1);
                if (m_if.tvalid && m_tready && sb.size() != 0) begin
                    chk($sformatf("lane%0d m_tdata", g), m_if.tdata, sb[0]);
                    void'(sb.pop_front());
                end
                if (s_tvalid && s_if.tready) sb.push_back(s_tdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] ctr, base, expd;
        int acc, nout, nin, wraps, nacc, pr;
        logic got;
        bit full;

        rst = 1'b1; s_tvalid = 1'b0; m_tready = 1'b0; s_tdata = '0;
        step(); step();
        @(negedge clk);
        chk("rst s_tready", 64'(o_srdy[0]), 0);
        chk("rst m_tvalid", 64'(o_mvld[0]), 0);
        chk("rst m_tdata", o_mdat[0], 0);
        chk("rst level", 64'(o_lvl[0]), 0);
        chk("rst ram_ena", 64'(o_ena[0]), 0);
        chk("rst ram_wea", 64'(o_wea[0]), 0);
        chk("rst ram_enb", 64'(o_enb[0]), 0);
        chk("rst ram_addra", 64'(o_addra[0]), 0);
        chk("rst ram_addrb", 64'(o_addrb[0]), 0);
        chk("rst ram_regceb", 64'(o_regceb[0]), 1);
        chk("rst ram_rstb", 64'(o_rstb[0]), 1);
        step(); rst = 1'b0;
        @(negedge clk);
        chk("post-rst level", 64'(o_lvl[0]), 0);
        chk("post-rst m_tvalid", 64'(o_mvld[0]), 0);
        chk("post-rst ram_rstb", 64'(o_rstb[0]), 0);

        // single beat: accepted at E0, visible for one cycle after E3
        step(); s_tdata = 64'hA5; s_tvalid = 1'b1; m_tready = 1'b1;
        @(negedge clk);
        chk("single s_tready", 64'(o_srdy[0]), 1);
        step(); s_tvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("single m_tvalid after E%0d", k), 64'(o_mvld[0]), 64'(k == 3));
            if (k == 3) chk("single m_tdata", o_mdat[0], 64'hA5);
            step();
        end
        @(negedge clk);
        chk("single level", 64'(o_lvl[0]), 0);

        // fill with no drain: capacity DEPTH + RD_LATENCY + 1
        step(); m_tready = 1'b0; s_tvalid = 1'b1; ctr = 1; s_tdata = ctr; acc = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            got = o_srdy[0];
            if (got) acc++;
            step();
            if (got) begin ctr++; s_tdata = ctr; end
        end
        @(negedge clk);
        chk("fill accepted", 64'(acc), 258);
        chk("fill s_tready", 64'(o_srdy[0]), 0);
        chk("fill level", 64'(o_lvl[0]), 258);
        chk("fill ram_ena", 64'(o_ena[0]), 0);
        step(); s_tvalid = 1'b0; m_tready = 1'b1; expd = 1; nout = 0;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            if (o_mvld[0]) begin
                chk("drain data", o_mdat[0], expd);
                expd++; nout++;
            end
            step();
        end
        chk("drain count", 64'(nout), 258);

        // full boundary: a pop while full frees a slot only for the next cycle
        m_tready = 1'b0; s_tvalid = 1'b1; ctr++; s_tdata = ctr; full = 1'b0;
        for (int c = 0; c < 400 && !full; c++) begin
            @(negedge clk);
            if (!o_srdy[0]) full = 1'b1;
            else begin step(); ctr++; s_tdata = ctr; end
        end
        chk("full level", 64'(o_lvl[0]), 258);
        step(); m_tready = 1'b1;
        @(negedge clk);
        chk("full pop s_tready", 64'(o_srdy[0]), 0);
        chk("full pop m_tvalid", 64'(o_mvld[0]), 1);
        chk("full pop ram_enb", 64'(o_enb[0]), 1);
        step(); m_tready = 1'b0;
        @(negedge clk);
        chk("full rise s_tready", 64'(o_srdy[0]), 1);
        chk("full rise level", 64'(o_lvl[0]), 257);
        step(); ctr++; s_tdata = ctr;
        @(negedge clk);
        chk("full refill level", 64'(o_lvl[0]), 258);
        chk("full refill s_tready", 64'(o_srdy[0]), 0);
        step(); s_tvalid = 1'b0; m_tready = 1'b1;
        repeat (800) step();
        @(negedge clk);
        for (int l = 0; l < NL; l++) chk($sformatf("lane%0d drained", l), 64'(o_lvl[l]), 0);

        // streaming 2000 beats through lane 0, pointers wrap repeatedly
        step(); s_tvalid = 1'b1; ctr++; s_tdata = ctr; base = ctr; nin = 0; nout = 0; wraps = 0;
        for (int c = 0; c < 6000 && nout < 2000; c++) begin
            @(negedge clk);
            got = s_tvalid && o_srdy[0];
            if (got) begin
                nin++;
                if (o_addra[0] == 8'hFF) wraps++;
            end
            if (o_mvld[0]) begin
                chk("stream data", o_mdat[0], base + 64'(nout));
                nout++;
            end
            step();
            if (got) begin
                ctr++; s_tdata = ctr;
                if (nin == 2000) s_tvalid = 1'b0;
            end
        end
        chk("stream count", 64'(nout), 2000);
        chk("stream wraps>=7", 64'(wraps >= 7), 1);

        // reset mid-operation with reads in flight
        repeat (20) step();
        m_tready = 1'b0; s_tvalid = 1'b1; acc = 0;
        for (int c = 0; c < 100 && acc < 40; c++) begin
            @(negedge clk);
            got = o_srdy[0];
            if (got) acc++;
            step();
            if (got) begin ctr++; s_tdata = ctr; end
        end
        s_tvalid = 1'b0; m_tready = 1'b1;
        step(); rst = 1'b1; m_tready = 1'b0;
        @(negedge clk);
        chk("mid-rst s_tready", 64'(o_srdy[0]), 0);
        chk("mid-rst m_tvalid", 64'(o_mvld[0]), 0);
        chk("mid-rst level", 64'(o_lvl[0]), 0);
        step(); rst = 1'b0;
        @(negedge clk);
        chk("after-rst m_tvalid", 64'(o_mvld[0]), 0);
        chk("after-rst m_tdata", o_mdat[0], 0);
        chk("after-rst level", 64'(o_lvl[0]), 0);
        chk("after-rst ram_enb", 64'(o_enb[0]), 0);
        chk("after-rst ram_ena", 64'(o_ena[0]), 0);
        chk("after-rst ram_addra", 64'(o_addra[0]), 0);
        chk("after-rst ram_addrb", 64'(o_addrb[0]), 0);
        step(); s_tdata = 64'h1; s_tvalid = 1'b1; m_tready = 1'b1;
        step(); s_tdata = 64'h2;
        step(); s_tvalid = 1'b0;
        nout = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_mvld[0]) begin
                chk("post-rst data", o_mdat[0], 64'(nout + 1));
                nout++;
            end
            step();
        end
        chk("post-rst count", 64'(nout), 2);

        // random valid/backpressure with fresh random data every cycle
        nacc = 0; pr = 60;
        for (int c = 0; c < 40000 && nacc < 10000; c++) begin
            if (c % 500 == 0) pr = (c / 500) % 3 == 0 ? 20 : ((c / 500) % 3 == 1 ? 60 : 95);
            s_tvalid = ($urandom_range(0, 99) < 70);
            m_tready = ($urandom_range(0, 99) < pr);
            s_tdata  = {$urandom, $urandom};
            @(negedge clk);
            if (s_tvalid && o_srdy[0]) nacc++;
            step();
        end
        chk("random beats", 64'(nacc >= 10000), 1);
        s_tvalid = 1'b0; m_tready = 1'b1;
        repeat (1000) step();
        @(negedge clk);
        for (int l = 0; l < NL; l++) chk($sformatf("lane%0d final level", l), 64'(o_lvl[l]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
